jtbubl_snd_comm: RTL and testbench

Sound-board end of the main-to-sound command link. It captures the command byte the main CPU writes and raises NMI on the sound CPU. It also holds a reply byte from the sound CPU for the main CPU, plus status/overrun flags readable by both sides. It sits between the main CPU bus (sound-latch window) and the sound Z80 bus, and replaces the bare snd_latch register with a full handshake.

---
 rtl/jtbubl_snd_comm_pkg.sv | 38 +++
 rtl/jtbubl_comm_edge.sv | 21 ++
 rtl/jtbubl_snd_comm.sv | 150 +++++++++++++++
 tb/tb_jtbubl_snd_comm.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtbubl_snd_comm_pkg.sv
// Shared definitions for the main-to-sound command link: status bit
// positions, sound-side register map and the NMI sequencer states.
package jtbubl_snd_comm_pkg;

    // Status byte bit positions (upper nibble always reads 0)
    localparam int ST_CMD_FULL   = 0;
    localparam int ST_REPLY_FULL = 1;
    localparam int ST_CMD_OVR    = 2;
    localparam int ST_REPLY_OVR  = 3;

    // Sound CPU register addresses
    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_NMI_EN  = 2'd1;
    localparam logic [1:0] REG_NMI_DIS = 2'd2;
    localparam logic [1:0] REG_CLR     = 2'd3;

    // NMI pulse counter width; covers pulse widths of 1..15 cen ticks
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_WAIT  = 2'd2
    } nmi_state_t;

    // Assemble the status byte seen by both CPUs
    function automatic logic [7:0] make_status(input logic cmd_full, input logic reply_full,
                                               input logic cmd_ovr,  input logic reply_ovr);
        logic [7:0] st;
        st                = 8'h00;
        st[ST_CMD_FULL]   = cmd_full;
        st[ST_REPLY_FULL] = reply_full;
        st[ST_CMD_OVR]    = cmd_ovr;
        st[ST_REPLY_OVR]  = reply_ovr;
        return st;
    endfunction

endpackage

// File: rtl/jtbubl_comm_edge.sv
// Access event generator: one clk24-wide event on the first cycle a chip
// select is seen high after being low. A held select produces nothing more.
module jtbubl_comm_edge (
    input  logic clk24,
    input  logic rst_n,
    input  logic cs,
    output logic ev
);

    logic cs_l;

    // Remember last cycle's select level
    always_ff @(posedge clk24 or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) cs_l <= 1'b0;
        else        cs_l <= cs;
    end

    assign ev = cs & ~cs_l;

endmodule

// File: rtl/jtbubl_snd_comm.sv
// Sound-board end of the main-to-sound command link: command/reply latches,
// full/overrun flags, registered read ports and the NMI pulse sequencer.
module jtbubl_snd_comm
    import jtbubl_snd_comm_pkg::*;
#(
    parameter int NMI_W = 4
) (
    input  logic       clk24,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       main_cs,
    input  logic       main_wrn,
    input  logic       main_addr,
    input  logic [7:0] main_din,
    output logic [7:0] main_dout,
    input  logic       snd_cs,
    input  logic       snd_rnw,
    input  logic [1:0] snd_addr,
    input  logic [7:0] snd_din,
    output logic [7:0] snd_dout,
    output logic       snd_nmi_n
);

    logic m_ev, s_ev;
    logic m_wr_cmd, m_rd_reply;
    logic s_rd_cmd, s_wr_reply, s_nmi_en, s_nmi_dis, s_clr;

    logic [7:0] cmd, reply, status;
    logic       cmd_full, reply_full, cmd_ovr, reply_ovr, nmi_en;

    nmi_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             nmi_n_r, nmi_n_nxt;
    logic             rearm, rearm_nxt;

    jtbubl_comm_edge u_main_edge (.clk24(clk24), .rst_n(rst_n), .cs(main_cs), .ev(m_ev));
    jtbubl_comm_edge u_snd_edge  (.clk24(clk24), .rst_n(rst_n), .cs(snd_cs),  .ev(s_ev));

    // Decode access events into register operations
    always_comb begin
        m_wr_cmd   = m_ev & ~main_wrn & ~main_addr;
        m_rd_reply = m_ev &  main_wrn & ~main_addr;
        s_rd_cmd   = s_ev &  snd_rnw  & (snd_addr == REG_DATA);
        s_wr_reply = s_ev & ~snd_rnw  & (snd_addr == REG_DATA);
        s_nmi_en   = s_ev & ~snd_rnw  & (snd_addr == REG_NMI_EN);
        s_nmi_dis  = s_ev & ~snd_rnw  & (snd_addr == REG_NMI_DIS);
        s_clr      = s_ev & ~snd_rnw  & (snd_addr == REG_CLR);
    end

    assign status = make_status(cmd_full, reply_full, cmd_ovr, reply_ovr);

    // Command/reply latches and handshake flags; set beats clear, and
    // overrun looks at the pre-edge full flag
    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            cmd        <= 8'h00;
            reply      <= 8'h00;
            cmd_full   <= 1'b0;
            reply_full <= 1'b0;
            cmd_ovr    <= 1'b0;
            reply_ovr  <= 1'b0;
            nmi_en     <= 1'b0;
        end else begin
            if (m_wr_cmd)   cmd   <= main_din;
            if (s_wr_reply) reply <= snd_din;

            if (m_wr_cmd)      cmd_full <= 1'b1;
            else if (s_rd_cmd) cmd_full <= 1'b0;

            if (s_wr_reply)      reply_full <= 1'b1;
            else if (m_rd_reply) reply_full <= 1'b0;

            // A command consumed in the same cycle it is replaced is not lost
            if (m_wr_cmd && cmd_full && !s_rd_cmd) cmd_ovr <= 1'b1;
            else if (s_clr)                        cmd_ovr <= 1'b0;

            if (s_wr_reply && reply_full) reply_ovr <= 1'b1;
            else if (s_clr)               reply_ovr <= 1'b0;

            if (s_nmi_en)       nmi_en <= 1'b1;
            else if (s_nmi_dis) nmi_en <= 1'b0;
        end
    end

    // Registered read ports, refreshed every cycle from the current address
    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            main_dout <= 8'h00;
            snd_dout  <= 8'h00;
        end else begin
            main_dout <= main_addr ? status : reply;
            case (snd_addr)
                REG_DATA:   snd_dout <= cmd;
                REG_NMI_EN: snd_dout <= status;
                default:    snd_dout <= 8'hff;
            endcase
        end
    end

    // NMI sequencer state register
    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            nmi_n_r <= 1'b1;
            rearm   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            nmi_n_r <= nmi_n_nxt;
            rearm   <= rearm_nxt;
        end
    end

    // NMI sequencer next state: one fixed-width pulse per pending command
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        nmi_n_nxt = nmi_n_r;
        rearm_nxt = rearm;
        case (state)
            S_IDLE: begin
                if (cmd_full && nmi_en) begin
                    state_nxt = S_PULSE;
                    cnt_nxt   = CNT_W'(NMI_W);
                    nmi_n_nxt = 1'b0;
                end
            end
            S_PULSE: begin
                if (m_wr_cmd) rearm_nxt = 1'b1;
                if (cen) begin
                    cnt_nxt = cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        nmi_n_nxt = 1'b1;
                        rearm_nxt = 1'b0;
                        state_nxt = (rearm || m_wr_cmd) ? S_IDLE : S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!cmd_full || m_wr_cmd) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign snd_nmi_n = nmi_n_r;

endmodule

// File: tb/tb_jtbubl_snd_comm.sv
// Self-checking bench for jtbubl_snd_comm: directed handshake scenarios with
// literal expectations, then randomized traffic against a behavioural model.
module tb_jtbubl_snd_comm;

    localparam int NMI_W = 4;

    logic       clk24 = 1'b0;
    logic       rst_n = 1'b0;
    logic       cen = 1'b0;
    logic       main_cs = 1'b0, main_wrn = 1'b1, main_addr = 1'b0;
    logic [7:0] main_din = 8'h00;
    logic [7:0] main_dout;
    logic       snd_cs = 1'b0, snd_rnw = 1'b1;
    logic [1:0] snd_addr = 2'd0;
    logic [7:0] snd_din = 8'h00;
    logic [7:0] snd_dout;
    logic       snd_nmi_n;

    jtbubl_snd_comm #(.NMI_W(NMI_W)) dut (
        .clk24(clk24), .rst_n(rst_n), .cen(cen),
        .main_cs(main_cs), .main_wrn(main_wrn), .main_addr(main_addr),
        .main_din(main_din), .main_dout(main_dout),
        .snd_cs(snd_cs), .snd_rnw(snd_rnw), .snd_addr(snd_addr),
        .snd_din(snd_din), .snd_dout(snd_dout), .snd_nmi_n(snd_nmi_n)
    );

    always #5 clk24 = ~clk24;

    int tests = 0;
    int fails = 0;
    int pulses = 0;     // completed NMI pulses observed on the DUT
    int low_ticks = 0;  // cen ticks seen while the DUT holds NMI low

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit [7:0] m_cmd, m_reply, m_mdout, m_sdout;
    bit       m_cf, m_rf, m_co, m_ro, m_en;
    bit       m_served;   // a pulse was already given for the pending command
    bit       m_rearm;    // a new command arrived while the pulse was out
    int       m_left;     // cen ticks of NMI still owed; 0 = line released
    bit       m_pcs_m, m_pcs_s;

    function automatic bit [7:0] m_status();
        return {4'b0000, m_ro, m_co, m_rf, m_cf};
    endfunction

    task automatic model_reset();
        m_cmd = 0; m_reply = 0; m_mdout = 0; m_sdout = 0;
        m_cf = 0; m_rf = 0; m_co = 0; m_ro = 0; m_en = 0;
        m_served = 0; m_rearm = 0; m_left = 0;
        m_pcs_m = 0; m_pcs_s = 0;
    endtask

    // Advance one clk24: predict, clock, then compare every output
    task automatic cycle();
        bit me, se, mw, mr, sr, sw, sen, sdis, sclr, pre_low;
        bit [7:0] st, n_mdout, n_sdout, n_cmd, n_reply;
        bit n_cf, n_rf, n_co, n_ro, n_en, n_served, n_rearm;
        int n_left;

        me   = main_cs && !m_pcs_m;
        se   = snd_cs && !m_pcs_s;
        mw   = me && !main_wrn && !main_addr;
        mr   = me && main_wrn && !main_addr;
        sr   = se && snd_rnw && snd_addr == 2'd0;
        sw   = se && !snd_rnw && snd_addr == 2'd0;
        sen  = se && !snd_rnw && snd_addr == 2'd1;
        sdis = se && !snd_rnw && snd_addr == 2'd2;
        sclr = se && !snd_rnw && snd_addr == 2'd3;

        st      = m_status();
        n_mdout = main_addr ? st : m_reply;
        n_sdout = (snd_addr == 2'd0) ? m_cmd : (snd_addr == 2'd1) ? st : 8'hff;

        n_cmd   = mw ? main_din : m_cmd;
        n_reply = sw ? snd_din : m_reply;
        n_cf    = mw ? 1'b1 : (sr ? 1'b0 : m_cf);
        n_rf    = sw ? 1'b1 : (mr ? 1'b0 : m_rf);
        n_co    = (mw && m_cf && !sr) ? 1'b1 : (sclr ? 1'b0 : m_co);
        n_ro    = (sw && m_rf) ? 1'b1 : (sclr ? 1'b0 : m_ro);
        n_en    = sen ? 1'b1 : (sdis ? 1'b0 : m_en);

        n_left = m_left; n_served = m_served; n_rearm = m_rearm;
        if (m_left > 0) begin
            if (mw) n_rearm = 1;
            if (cen) begin
                n_left = m_left - 1;
                if (n_left == 0) begin
                    n_served = !(m_rearm || mw);
                    n_rearm  = 0;
                end
            end
        end else if (m_served) begin
            if (!m_cf || mw) n_served = 0;
        end else if (m_cf && m_en) begin
            n_left = NMI_W;
        end

        pre_low = (snd_nmi_n === 1'b0);
        if (pre_low && cen) low_ticks++;

        @(posedge clk24);
        #1;

        m_cmd = n_cmd; m_reply = n_reply; m_cf = n_cf; m_rf = n_rf;
        m_co = n_co; m_ro = n_ro; m_en = n_en;
        m_left = n_left; m_served = n_served; m_rearm = n_rearm;
        m_mdout = n_mdout; m_sdout = n_sdout;
        m_pcs_m = main_cs; m_pcs_s = snd_cs;

        if (pre_low && snd_nmi_n === 1'b1) pulses++;

        check("cyc_main_dout", main_dout, m_mdout);
        check("cyc_snd_dout",  snd_dout,  m_sdout);
        check("cyc_snd_nmi_n", snd_nmi_n, (m_left == 0));

        cen = ($urandom_range(0, 2) == 0);
    endtask

    task automatic main_acc(input bit wr, input bit a, input bit [7:0] d, output bit [7:0] rd);
        main_cs = 1; main_wrn = !wr; main_addr = a; main_din = d;
        cycle();
        rd = main_dout;
        main_cs = 0; main_wrn = 1;
        cycle();
    endtask

    task automatic snd_acc(input bit rnw, input bit [1:0] a, input bit [7:0] d, output bit [7:0] rd);
        snd_cs = 1; snd_rnw = rnw; snd_addr = a; snd_din = d;
        cycle();
        rd = snd_dout;
        snd_cs = 0; snd_rnw = 1;
        cycle();
    endtask

    // Run until the DUT completes one more NMI pulse, bounded
    task automatic wait_pulse(input int base, input string name);
        for (int i = 0; i < 200 && pulses == base; i++) cycle();
        check(name, pulses, base + 1);
    endtask

    initial begin
        bit [7:0] r;
        int base;

        model_reset();
        repeat (2) @(posedge clk24);
        #1;
        check("rst_main_dout", main_dout, 8'h00);
        check("rst_snd_dout",  snd_dout,  8'h00);
        check("rst_nmi_n",     snd_nmi_n, 1'b1);
        rst_n = 1;

        // 1: command with NMI disabled
        main_acc(1, 0, 8'h5A, r);
        repeat (4) cycle();
        check("t1_nmi_idle", snd_nmi_n, 1'b1);
        check("t1_pulses", pulses, 0);
        snd_acc(1, 1, 0, r);
        check("t1_status", r, 8'h01);

        // 2: deferred NMI on enable, exact width, then consume
        low_ticks = 0;
        snd_acc(0, 1, 0, r);
        wait_pulse(0, "t2_pulse_seen");
        check("t2_width", low_ticks, NMI_W);
        snd_acc(1, 0, 0, r);
        check("t2_cmd", r, 8'h5A);
        snd_acc(1, 1, 0, r);
        check("t2_status", r, 8'h00);
        repeat (20) cycle();
        check("t2_no_extra_pulse", pulses, 1);

        // 3: command overrun and flag clear
        main_acc(1, 0, 8'h11, r);
        main_acc(1, 0, 8'h22, r);
        snd_acc(1, 1, 0, r);
        check("t3_status_ovr", r, 8'h05);
        snd_addr = 2'd0;
        repeat (2) cycle();
        check("t3_cmd_peek", snd_dout, 8'h22);
        snd_acc(0, 3, 0, r);
        snd_acc(1, 1, 0, r);
        check("t3_status_clr", r, 8'h01);

        // 4: reply path
        snd_acc(1, 0, 0, r);
        check("t4_cmd", r, 8'h22);
        snd_acc(0, 0, 8'hC3, r);
        main_acc(0, 1, 0, r);
        check("t4_main_status", r, 8'h02);
        main_acc(0, 0, 0, r);
        check("t4_reply", r, 8'hC3);
        main_acc(0, 1, 0, r);
        check("t4_status_empty", r, 8'h00);

        // 5: write and read of the command in the same cycle
        repeat (30) cycle();
        base = pulses;
        main_acc(1, 0, 8'h33, r);
        wait_pulse(base, "t5_first_pulse");
        main_cs = 1; main_wrn = 0; main_addr = 0; main_din = 8'h44;
        snd_cs = 1; snd_rnw = 1; snd_addr = 2'd0;
        cycle();
        check("t5_read_old", snd_dout, 8'h33);
        main_cs = 0; main_wrn = 1; snd_cs = 0;
        base = pulses;
        cycle();
        main_acc(0, 1, 0, r);
        check("t5_status", r, 8'h01);
        wait_pulse(base, "t5_second_pulse");

        // 6: held select gives one event; async reset mid-pulse
        snd_acc(1, 0, 0, r);
        check("t6_cmd44", r, 8'h44);
        snd_acc(0, 3, 0, r);
        repeat (60) cycle();
        main_cs = 1; main_wrn = 0; main_addr = 0; main_din = 8'h77;
        cycle();
        main_din = 8'h88;
        repeat (49) cycle();
        main_cs = 0; main_wrn = 1;
        cycle();
        snd_acc(1, 1, 0, r);
        check("t6_one_event", r, 8'h01);
        snd_addr = 2'd0;
        repeat (2) cycle();
        check("t6_cmd_peek", snd_dout, 8'h77);
        main_acc(1, 0, 8'h99, r);
        for (int i = 0; i < 50 && snd_nmi_n !== 1'b0; i++) cycle();
        check("t6_pulse_started", snd_nmi_n, 1'b0);
        #2 rst_n = 0;
        #1;
        check("t6_rst_nmi", snd_nmi_n, 1'b1);
        check("t6_rst_main_dout", main_dout, 8'h00);
        model_reset();
        #2 rst_n = 1;
        main_acc(0, 1, 0, r);
        check("t6_main_status", r, 8'h00);
        snd_acc(1, 1, 0, r);
        check("t6_snd_status", r, 8'h00);

        // Randomized traffic against the model
        repeat (3000) begin
            main_cs   = ($urandom_range(0, 3) == 0);
            main_wrn  = $urandom_range(0, 1);
            main_addr = $urandom_range(0, 1);
            main_din  = 8'($urandom);
            snd_cs    = ($urandom_range(0, 3) == 0);
            snd_rnw   = $urandom_range(0, 1);
            snd_addr  = 2'($urandom_range(0, 3));
            snd_din   = 8'($urandom);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
